// File: rtl/reset_sequencer.sv
// reset_sequencer
// Reset generator: synchronises the release of the raw reset, then releases
// NUM_CHANNELS active-low reset outputs one after another. Software requests
// and an optional watchdog restart the sequence. The cause of the last reset
// is latched, and non-power-on resets are counted.
//
// Ports:
//   CLK          single clock
//   RST_N        raw asynchronous active-low reset
//   sw_rst_req   synchronous software reset request (1-cycle pulse suffices)
//   wdt_kick     synchronous watchdog service strobe
//   rst_n_out    per-channel active-low resets, bit 0 released first
//   all_released high once every channel is released
//   rst_cause    cause of the last reset: 00 RST_N, 01 software, 10 watchdog
//   rst_count    software + watchdog resets since last RST_N, saturating at 255
module reset_sequencer #(
  parameter int unsigned NUM_CHANNELS = 3,
  parameter int unsigned HOLD_CYCLES  = 16,
  parameter int unsigned STAGE_GAP    = 8,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned WDT_CYCLES   = 0
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    sw_rst_req,
  input  logic                    wdt_kick,
  output logic [NUM_CHANNELS-1:0] rst_n_out,
  output logic                    all_released,
  output logic [1:0]              rst_cause,
  output logic [7:0]              rst_count
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGE_GAP) ? HOLD_CYCLES : STAGE_GAP;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned IW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'b00,
    ST_RELEASE = 2'b01,
    ST_RUN     = 2'b10
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [NUM_CHANNELS-1:0] out_q, out_d;
  logic                    all_q, all_d;
  logic [1:0]              cause_q, cause_d;
  logic [7:0]              count_q, count_d;
  logic [SYNC_STAGES-1:0]  sync_q;
  logic                    sync_done;
  logic                    wdt_expire;

  // Release synchroniser: only the deassertion of RST_N is synchronised.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign sync_done = sync_q[SYNC_STAGES-1];

  generate
    if (WDT_CYCLES > 0) begin : g_wdt
      localparam int unsigned WW = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;
      logic [WW-1:0] wdt_q;

      // Held at zero outside RUN, so RUN entry always starts a fresh timeout.
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          wdt_q <= '0;
        end else if ((state_q != ST_RUN) || wdt_kick) begin
          wdt_q <= '0;
        end else begin
          wdt_q <= wdt_q + 1'b1;
        end
      end

      assign wdt_expire = (state_q == ST_RUN) && !wdt_kick &&
                          (wdt_q == WW'(WDT_CYCLES - 1));
    end else begin : g_no_wdt
      assign wdt_expire = wdt_kick & 1'b0;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      all_q   <= 1'b0;
      cause_q <= 2'b00;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      all_q   <= all_d;
      cause_q <= cause_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    all_d   = all_q;
    cause_d = cause_q;
    count_d = count_q;

    case (state_q)
      ST_ASSERT: begin
        if (sync_done) begin
          if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
            out_d[0] = 1'b1;
            cnt_d    = '0;
            if (NUM_CHANNELS == 1) begin
              all_d   = 1'b1;
              state_d = ST_RUN;
            end else begin
              idx_d   = IW'(1);
              state_d = ST_RELEASE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      ST_RELEASE: begin
        if (cnt_q == CW'(STAGE_GAP - 1)) begin
          cnt_d = '0;
          // OR-in only: released bits never drop until the next reset event.
          out_d = out_q | (NUM_CHANNELS'(1) << idx_q);
          if (idx_q == IW'(NUM_CHANNELS - 1)) begin
            all_d   = 1'b1;
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
      end

      default: begin
        state_d = ST_ASSERT;
      end
    endcase

    // Software request wins over a simultaneous watchdog expiry.
    if (sw_rst_req || wdt_expire) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '0;
      all_d   = 1'b0;
      cause_d = sw_rst_req ? CAUSE_SW : CAUSE_WDT;
      if (count_q != 8'hFF) begin
        count_d = count_q + 8'd1;
      end
    end
  end

  assign rst_n_out    = out_q;
  assign all_released = all_q;
  assign rst_cause    = cause_q;
  assign rst_count    = count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed stimulus pushes expected output changes
// (edge number + packed output value) into per-DUT queues; a monitor pops and
// compares whenever a DUT's outputs change.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sw, kick;
  logic [2:0] out0;
  logic       all0;
  logic [1:0] cause0;
  logic [7:0] count0;

  logic       r1_n, sw1, kick1;
  logic [0:0] out1;
  logic       all1;
  logic [1:0] cause1;
  logic [7:0] count1;

  reset_sequencer #(.WDT_CYCLES(100)) u_dut (
    .CLK(clk), .RST_N(rst_n), .sw_rst_req(sw), .wdt_kick(kick),
    .rst_n_out(out0), .all_released(all0), .rst_cause(cause0), .rst_count(count0)
  );

  reset_sequencer #(
    .NUM_CHANNELS(1), .HOLD_CYCLES(4), .STAGE_GAP(2), .SYNC_STAGES(3), .WDT_CYCLES(0)
  ) u_dut1 (
    .CLK(clk), .RST_N(r1_n), .sw_rst_req(sw1), .wdt_kick(kick1),
    .rst_n_out(out1), .all_released(all1), .rst_cause(cause1), .rst_count(count1)
  );

  typedef struct {
    int unsigned cyc;
    logic [13:0] val;
  } ev_t;

  ev_t         q0[$];
  ev_t         q1[$];
  int unsigned cyc = 0;
  int          errors = 0;
  int          checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [13:0] obs0, obs1, prev0, prev1;
  assign obs0 = {out0, all0, cause0, count0};
  assign obs1 = {2'b00, out1, all1, cause1, count1};

  function automatic logic [13:0] pk(input logic [2:0] o, input logic a,
                                     input logic [1:0] c, input logic [7:0] n);
    return {o, a, c, n};
  endfunction

  task automatic exp0(input int unsigned c, input logic [13:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q0.push_back(e);
  endtask

  task automatic exp1(input int unsigned c, input logic [13:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    q1.push_back(e);
  endtask

  task automatic check_ev(input int d, input logic [13:0] v);
    ev_t e;
    int  sz;
    checks++;
    sz = (d == 0) ? q0.size() : q1.size();
    if (sz == 0) begin
      errors++;
      $display("FAIL unexpected_change dut%0d: at cyc=%0d got val=%h, required no change", d, cyc, v);
    end else begin
      if (d == 0) e = q0.pop_front();
      else        e = q1.pop_front();
      if ((e.cyc != cyc) || (e.val !== v)) begin
        errors++;
        $display("FAIL output_event dut%0d: got cyc=%0d val=%h, required cyc=%0d val=%h",
                 d, cyc, v, e.cyc, e.val);
      end
    end
  endtask

  task automatic check_direct(input string name, input logic [13:0] got, input logic [13:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, req);
    end
  endtask

  initial begin
    @(negedge clk);
    prev0 = obs0;
    prev1 = obs1;
    forever begin
      @(negedge clk);
      if (obs0 !== prev0) begin
        check_ev(0, obs0);
        prev0 = obs0;
      end
      if (obs1 !== prev1) begin
        check_ev(1, obs1);
        prev1 = obs1;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int unsigned b, t, l, k, s;

  initial begin
    rst_n = 1'b0; sw = 1'b0; kick = 1'b1;
    r1_n  = 1'b0; sw1 = 1'b0; kick1 = 1'b0;
    tick(5);
    check_direct("reset_out",   14'(out0),   14'd0);
    check_direct("reset_all",   14'(all0),   14'd0);
    check_direct("reset_cause", 14'(cause0), 14'd0);
    check_direct("reset_count", 14'(count0), 14'd0);

    // Power-on with defaults: bits at 18, 26, 34 after the rise.
    b = cyc;
    rst_n = 1'b1;
    exp0(b + 18, pk(3'b001, 1'b0, 2'b00, 8'd0));
    exp0(b + 26, pk(3'b011, 1'b0, 2'b00, 8'd0));
    exp0(b + 34, pk(3'b111, 1'b1, 2'b00, 8'd0));
    tick(40);

    // RST_N drop from RUN, then a re-rise pulsed low again at edge 22.
    exp0(cyc, pk(3'b000, 1'b0, 2'b00, 8'd0));
    rst_n = 1'b0;
    #1 check_direct("async_drop_run", 14'(out0), 14'd0);
    tick(3);
    b = cyc;
    rst_n = 1'b1;
    exp0(b + 18, pk(3'b001, 1'b0, 2'b00, 8'd0));
    tick(22);
    exp0(cyc, pk(3'b000, 1'b0, 2'b00, 8'd0));
    rst_n = 1'b0;
    #1 check_direct("async_drop_mid", 14'(out0), 14'd0);
    tick(2);
    b = cyc;
    rst_n = 1'b1;
    exp0(b + 18, pk(3'b001, 1'b0, 2'b00, 8'd0));
    exp0(b + 26, pk(3'b011, 1'b0, 2'b00, 8'd0));
    exp0(b + 34, pk(3'b111, 1'b1, 2'b00, 8'd0));
    tick(40);

    // Software reset in RUN.
    t = cyc + 1;
    exp0(t,      pk(3'b000, 1'b0, 2'b01, 8'd1));
    exp0(t + 16, pk(3'b001, 1'b0, 2'b01, 8'd1));
    exp0(t + 24, pk(3'b011, 1'b0, 2'b01, 8'd1));
    exp0(t + 32, pk(3'b111, 1'b1, 2'b01, 8'd1));
    sw = 1'b1; tick(1); sw = 1'b0;
    tick(40);

    // Fresh power-on, then software reset at edge 30 while outputs are 011.
    exp0(cyc, pk(3'b000, 1'b0, 2'b00, 8'd0));
    rst_n = 1'b0;
    tick(3);
    b = cyc;
    rst_n = 1'b1;
    exp0(b + 18, pk(3'b001, 1'b0, 2'b00, 8'd0));
    exp0(b + 26, pk(3'b011, 1'b0, 2'b00, 8'd0));
    exp0(b + 30, pk(3'b000, 1'b0, 2'b01, 8'd1));
    exp0(b + 46, pk(3'b001, 1'b0, 2'b01, 8'd1));
    exp0(b + 54, pk(3'b011, 1'b0, 2'b01, 8'd1));
    exp0(b + 62, pk(3'b111, 1'b1, 2'b01, 8'd1));
    tick(29);
    sw = 1'b1; tick(1); sw = 1'b0;
    tick(40);

    // Watchdog: kicks every 50 cycles for 1000 cycles, then none.
    for (int i = 0; i < 20; i++) begin
      kick = 1'b0;
      tick(49);
      kick = 1'b1;
      tick(1);
    end
    kick = 1'b0;
    l = cyc;
    exp0(l + 100, pk(3'b000, 1'b0, 2'b10, 8'd2));
    exp0(l + 116, pk(3'b001, 1'b0, 2'b10, 8'd2));
    exp0(l + 124, pk(3'b011, 1'b0, 2'b10, 8'd2));
    exp0(l + 132, pk(3'b111, 1'b1, 2'b10, 8'd2));
    tick(110);
    kick = 1'b1;
    tick(40);

    // Kick in the expiry cycle cancels; next expiry collides with a request.
    k = cyc;
    kick = 1'b0;
    tick(99);
    kick = 1'b1;
    tick(1);
    kick = 1'b0;
    tick(99);
    exp0(k + 200, pk(3'b000, 1'b0, 2'b01, 8'd3));
    exp0(k + 216, pk(3'b001, 1'b0, 2'b01, 8'd3));
    exp0(k + 224, pk(3'b011, 1'b0, 2'b01, 8'd3));
    exp0(k + 232, pk(3'b111, 1'b1, 2'b01, 8'd3));
    sw = 1'b1; tick(1); sw = 1'b0; kick = 1'b1;
    tick(40);

    // 300 back-to-back software resets saturate the counter.
    s = cyc;
    for (int unsigned j = 1; j <= 252; j++)
      exp0(s + j, pk(3'b000, 1'b0, 2'b01, 8'(3 + j)));
    exp0(s + 316, pk(3'b001, 1'b0, 2'b01, 8'd255));
    exp0(s + 324, pk(3'b011, 1'b0, 2'b01, 8'd255));
    exp0(s + 332, pk(3'b111, 1'b1, 2'b01, 8'd255));
    sw = 1'b1;
    tick(300);
    sw = 1'b0;
    tick(40);
    check_direct("count_saturated", 14'(count0), 14'd255);
    t = cyc + 1;
    exp0(t,      pk(3'b000, 1'b0, 2'b01, 8'd255));
    exp0(t + 16, pk(3'b001, 1'b0, 2'b01, 8'd255));
    exp0(t + 24, pk(3'b011, 1'b0, 2'b01, 8'd255));
    exp0(t + 32, pk(3'b111, 1'b1, 2'b01, 8'd255));
    sw = 1'b1; tick(1); sw = 1'b0;
    tick(40);

    // Single-channel instance: all_released with bit 0, 3-stage sync.
    check_direct("dut1_reset", obs1, 14'd0);
    b = cyc;
    r1_n = 1'b1;
    exp1(b + 7, pk(3'b001, 1'b1, 2'b00, 8'd0));
    tick(15);
    t = cyc + 1;
    exp1(t,     pk(3'b000, 1'b0, 2'b01, 8'd1));
    exp1(t + 4, pk(3'b001, 1'b1, 2'b01, 8'd1));
    sw1 = 1'b1; tick(1); sw1 = 1'b0;
    tick(10);
    t = cyc + 1;
    exp1(t,     pk(3'b000, 1'b0, 2'b01, 8'd2));
    exp1(t + 2, pk(3'b000, 1'b0, 2'b01, 8'd3));
    exp1(t + 6, pk(3'b001, 1'b1, 2'b01, 8'd3));
    sw1 = 1'b1; tick(1); sw1 = 1'b0;
    tick(1);
    sw1 = 1'b1; tick(1); sw1 = 1'b0;
    tick(10);
    exp1(cyc, pk(3'b000, 1'b0, 2'b00, 8'd0));
    r1_n = 1'b0;
    #1 check_direct("dut1_async_drop", obs1, 14'd0);
    tick(3);

    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL pending_events dut0: got %0d outstanding, required 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL pending_events dut1: got %0d outstanding, required 0", q1.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
